frv_rngif_pf: RTL and testbench

Next-generation CPU-side random number generator interface with a parametrised prefetch buffer. It sits in the execute stage between the pipeline's RNG micro-ops (test, seed, sample) and the external RNG request/response channels. While the RNG reports healthy, the block fills a DEPTH-entry sample FIFO in the background, so a sample instruction that hits the buffer completes with zero added latency. Test, seed and buffer-miss samples are forwarded to the RNG directly, and the block arbitrates these against background prefetch traffic.

---
 rtl/frv_rngif_pf_if.sv | 34 +++
 rtl/frv_rngif_pf.sv | 309 ++++++++++++++++++++++++++++++
 tb/tb_frv_rngif_pf.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/frv_rngif_pf_if.sv
// RNG request/response channel bundle between the CPU-side interface block
// (master) and the external random number generator (slave).
interface frv_rngif_pf_if;
  logic        rng_req_valid;
  logic [2:0]  rng_req_op;
  logic [31:0] rng_req_data;
  logic        rng_req_ready;
  logic        rng_rsp_valid;
  logic [2:0]  rng_rsp_status;
  logic [31:0] rng_rsp_data;
  logic        rng_rsp_ready;

  modport master (
    output rng_req_valid,
    output rng_req_op,
    output rng_req_data,
    input  rng_req_ready,
    input  rng_rsp_valid,
    input  rng_rsp_status,
    input  rng_rsp_data,
    output rng_rsp_ready
  );

  modport slave (
    input  rng_req_valid,
    input  rng_req_op,
    input  rng_req_data,
    output rng_req_ready,
    output rng_rsp_valid,
    output rng_rsp_status,
    output rng_rsp_data,
    input  rng_rsp_ready
  );
endinterface

// File: rtl/frv_rngif_pf.sv
// CPU-side RNG interface with a background prefetch FIFO.
// Sample micro-ops that find buffered entropy complete in the same cycle;
// test, seed and buffer-miss samples go straight to the RNG and are
// arbitrated against prefetch traffic by a single request FSM.
module frv_rngif_pf #(
  parameter int         XLEN           = 32,
  parameter int         DEPTH          = 4,
  parameter logic [2:0] STATUS_HEALTHY = 3'd1,
  parameter int         CW             = $clog2(DEPTH + 1)
) (
  input  logic                 g_clk,
  input  logic                 g_resetn,
  input  logic                 flush,
  input  logic                 pipeline_progress,
  input  logic                 valid,
  input  logic [XLEN-1:0]      rs1,
  input  logic                 uop_test,
  input  logic                 uop_seed,
  input  logic                 uop_samp,
  frv_rngif_pf_if.master       rng,
  output logic [XLEN-1:0]      result,
  output logic                 ready,
  output logic [CW-1:0]        count
);

  localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW-1:0] PTR_ZERO = AW'(0);
  localparam logic [2:0]    OP_TEST  = 3'b100;
  localparam logic [2:0]    OP_SAMP  = 3'b010;
  localparam logic [2:0]    OP_SEED  = 3'b001;
  localparam logic [2:0]    OP_NONE  = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PF_REQ  = 3'd1,
    ST_PF_RSP  = 3'd2,
    ST_CPU_REQ = 3'd3,
    ST_CPU_RSP = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [31:0]       data_q, data_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic              flushed_q, flushed_d;
  logic              hf_q, hf_d;
  logic [CW-1:0]     count_q, count_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [31:0]       fifo_q [DEPTH];

  logic              rsp_ready_s;
  logic              rsp_fire_s;
  logic              status_ok_s;
  logic              cpu_busy_s;
  logic              hit_s;
  logic              push_s;
  logic              pop_s;
  logic              seed_clr_s;

  // A micro-op needs the RNG itself unless it is a sample the FIFO can serve.
  function automatic logic cpu_need(
    input logic          v,
    input logic          f,
    input logic          t,
    input logic          s,
    input logic          p,
    input logic [CW-1:0] c
  );
    return v && !f && (t || s || (p && (c == CNT_ZERO)));
  endfunction

  assign rsp_ready_s = (state_q == ST_PF_RSP) || (state_q == ST_CPU_RSP);
  assign rsp_fire_s  = rsp_ready_s && rng.rng_rsp_valid;
  assign status_ok_s = (rng.rng_rsp_status == STATUS_HEALTHY);
  assign cpu_busy_s  = (state_q == ST_CPU_REQ) || (state_q == ST_CPU_RSP) ||
                       (state_q == ST_DONE);
  assign hit_s       = valid && uop_samp && (count_q != CNT_ZERO) && !cpu_busy_s;
  assign pop_s       = hit_s && pipeline_progress;
  // A full FIFO cannot be reached here in practice, but a push is still refused.
  assign push_s      = (state_q == ST_PF_RSP) && rsp_fire_s && status_ok_s &&
                       (count_q != CNT_FULL);
  // Buffered samples predate freshly injected entropy, so a seed discards them.
  assign seed_clr_s  = (state_q == ST_CPU_REQ) && rng.rng_req_ready &&
                       (op_q == OP_SEED);

  // FIFO pointer and occupancy next-state.
  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (seed_clr_s) begin
      count_d  = CNT_ZERO;
      rd_ptr_d = PTR_ZERO;
      wr_ptr_d = PTR_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Request FSM: arbitration, op capture, result capture and health tracking.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    data_d    = data_q;
    res_d     = res_q;
    flushed_d = flushed_q;
    hf_d      = hf_q;

    if (rsp_fire_s) begin
      hf_d = status_ok_s;
    end else begin
      hf_d = hf_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (cpu_need(valid, flush, uop_test, uop_seed, uop_samp, count_q)) begin
          state_d   = ST_CPU_REQ;
          op_d      = {uop_test, uop_samp, uop_seed};
          data_d    = rs1[31:0];
          flushed_d = 1'b0;
        end else if (hf_q && (count_q < CNT_FULL)) begin
          state_d = ST_PF_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_PF_REQ: begin
        if (rng.rng_req_ready) begin
          state_d = ST_PF_RSP;
        end else begin
          state_d = ST_PF_REQ;
        end
      end

      // Completing a prefetch applies the idle arbitration directly (on the
      // post-push occupancy and fresh health) so back-to-back prefetches
      // sustain one sample every two cycles.
      ST_PF_RSP: begin
        if (rng.rng_rsp_valid) begin
          if (cpu_need(valid, flush, uop_test, uop_seed, uop_samp, count_d)) begin
            state_d   = ST_CPU_REQ;
            op_d      = {uop_test, uop_samp, uop_seed};
            data_d    = rs1[31:0];
            flushed_d = 1'b0;
          end else if (status_ok_s && (count_d < CNT_FULL)) begin
            state_d = ST_PF_REQ;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_PF_RSP;
        end
      end

      // The request is never withdrawn; a flush only marks it for discard.
      ST_CPU_REQ: begin
        if (flush) begin
          flushed_d = 1'b1;
        end else begin
          flushed_d = flushed_q;
        end
        if (rng.rng_req_ready) begin
          state_d = ST_CPU_RSP;
        end else begin
          state_d = ST_CPU_REQ;
        end
      end

      ST_CPU_RSP: begin
        if (rng.rng_rsp_valid) begin
          if (flushed_q || flush) begin
            state_d   = ST_IDLE;
            flushed_d = 1'b0;
          end else begin
            state_d = ST_DONE;
            case (op_q)
              OP_SAMP: res_d = XLEN'(rng.rng_rsp_data);
              OP_TEST: res_d = XLEN'(status_ok_s);
              default: res_d = {XLEN{1'b0}};
            endcase
          end
        end else if (flush) begin
          flushed_d = 1'b1;
        end else begin
          flushed_d = flushed_q;
        end
      end

      ST_DONE: begin
        if (pipeline_progress || flush) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, captured operation and health flag registers.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_NONE;
      data_q    <= 32'h0000_0000;
      res_q     <= {XLEN{1'b0}};
      flushed_q <= 1'b0;
      hf_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      data_q    <= data_d;
      res_q     <= res_d;
      flushed_q <= flushed_d;
      hf_q      <= hf_d;
    end
  end

  // FIFO occupancy and pointer registers.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      count_q  <= CNT_ZERO;
      rd_ptr_q <= PTR_ZERO;
      wr_ptr_q <= PTR_ZERO;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // FIFO storage: write the healthy prefetched sample at the tail.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= 32'h0000_0000;
      end
    end else if (push_s) begin
      fifo_q[wr_ptr_q] <= rng.rng_rsp_data;
    end
  end

  // RNG channel drive, decoded purely from registered state.
  always_comb begin
    rng.rng_req_op   = OP_NONE;
    rng.rng_req_data = 32'h0000_0000;
    case (state_q)
      ST_PF_REQ: begin
        rng.rng_req_op   = OP_SAMP;
        rng.rng_req_data = 32'h0000_0000;
      end
      ST_CPU_REQ: begin
        rng.rng_req_op   = op_q;
        rng.rng_req_data = data_q;
      end
      default: begin
        rng.rng_req_op   = OP_NONE;
        rng.rng_req_data = 32'h0000_0000;
      end
    endcase
  end

  assign rng.rng_req_valid = (state_q == ST_PF_REQ) || (state_q == ST_CPU_REQ);
  assign rng.rng_rsp_ready = rsp_ready_s;

  // Pipeline write-back: held direct result, or the FIFO head on a hit.
  always_comb begin
    ready  = 1'b0;
    result = {XLEN{1'b0}};
    if (state_q == ST_DONE) begin
      ready  = 1'b1;
      result = res_q;
    end else if (hit_s) begin
      ready  = 1'b1;
      result = XLEN'(fifo_q[rd_ptr_q]);
    end else begin
      ready  = 1'b0;
      result = {XLEN{1'b0}};
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_frv_rngif_pf.sv
// Directed bench for frv_rngif_pf with a small RNG responder. Response n
// (counting every accepted response from reset) carries data 0x5A000000|n.
module tb_frv_rngif_pf;

  logic        g_clk = 1'b0;
  logic        g_resetn;
  logic        flush;
  logic        pipeline_progress;
  logic        valid;
  logic [31:0] rs1;
  logic        uop_test;
  logic        uop_seed;
  logic        uop_samp;
  logic [31:0] result;
  logic        ready;
  logic [2:0]  count;

  frv_rngif_pf_if rng_if ();

  frv_rngif_pf #(
    .XLEN(32), .DEPTH(4), .STATUS_HEALTHY(3'd1), .CW(3)
  ) dut (
    .g_clk(g_clk), .g_resetn(g_resetn), .flush(flush),
    .pipeline_progress(pipeline_progress), .valid(valid), .rs1(rs1),
    .uop_test(uop_test), .uop_seed(uop_seed), .uop_samp(uop_samp),
    .rng(rng_if), .result(result), .ready(ready), .count(count)
  );

  always #5 g_clk = ~g_clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // RNG-side monitor
  logic req_fire_q = 1'b0;
  logic rsp_fire_q = 1'b0;
  int   rsp_fires  = 0;
  int   pf_ops     = 0;
  always @(posedge g_clk) begin
    req_fire_q <= rng_if.rng_req_valid && rng_if.rng_req_ready;
    rsp_fire_q <= rng_if.rng_rsp_valid && rng_if.rng_rsp_ready;
    if (rng_if.rng_rsp_valid && rng_if.rng_rsp_ready) rsp_fires <= rsp_fires + 1;
    if (rng_if.rng_req_valid && rng_if.rng_req_ready && rng_if.rng_req_op == 3'b010)
      pf_ops <= pf_ops + 1;
  end

  // RNG responder
  logic [2:0] rsp_status_cfg = 3'd1;
  int         rsp_dly_cfg    = 0;
  initial begin
    int  dly;
    logic pend;
    dly  = 0;
    pend = 1'b0;
    rng_if.rng_rsp_valid  = 1'b0;
    rng_if.rng_rsp_status = 3'd0;
    rng_if.rng_rsp_data   = 32'd0;
    forever begin
      @(negedge g_clk);
      if (!g_resetn) begin
        rng_if.rng_rsp_valid = 1'b0;
        pend = 1'b0;
      end else begin
        if (rsp_fire_q) rng_if.rng_rsp_valid = 1'b0;
        if (req_fire_q) begin
          pend = 1'b1;
          dly  = rsp_dly_cfg;
        end
        if (pend && !rng_if.rng_rsp_valid) begin
          if (dly == 0) begin
            rng_if.rng_rsp_valid  = 1'b1;
            rng_if.rng_rsp_status = rsp_status_cfg;
            rng_if.rng_rsp_data   = 32'h5A00_0000 | 32'(rsp_fires);
            pend = 1'b0;
          end else begin
            dly--;
          end
        end
      end
    end
  end

  task automatic wait_ready(input int max_cyc, output int cyc);
    cyc = 0;
    do begin
      @(negedge g_clk); #1;
      cyc++;
    end while (!ready && cyc < max_cyc);
  endtask

  task automatic wait_full(input int max_cyc, output int cyc);
    cyc = 0;
    do begin
      @(negedge g_clk); #1;
      cyc++;
    end while (count != 3'd4 && cyc < max_cyc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int p0;
    int f0;
    logic seen;
    g_resetn = 1'b0; flush = 1'b0; pipeline_progress = 1'b0; valid = 1'b0;
    rs1 = 32'd0; uop_test = 1'b0; uop_seed = 1'b0; uop_samp = 1'b0;
    rng_if.rng_req_ready = 1'b1;

    // reset state
    repeat (3) @(negedge g_clk);
    #1;
    chk("rst_req_valid", 32'(rng_if.rng_req_valid), 32'd0);
    chk("rst_rsp_ready", 32'(rng_if.rng_rsp_ready), 32'd0);
    chk("rst_ready",     32'(ready), 32'd0);
    chk("rst_result",    result, 32'd0);
    chk("rst_count",     32'(count), 32'd0);
    chk("rst_req_op",    32'(rng_if.rng_req_op), 32'd0);
    chk("rst_req_data",  rng_if.rng_req_data, 32'd0);
    @(negedge g_clk); g_resetn = 1'b1;
    repeat (3) @(negedge g_clk);
    #1;
    chk("unhealthy_no_pf", 32'(rng_if.rng_req_valid), 32'd0);

    // test op, healthy status
    @(negedge g_clk); valid = 1'b1; uop_test = 1'b1;
    @(negedge g_clk); #1;
    chk("test_req_valid", 32'(rng_if.rng_req_valid), 32'd1);
    chk("test_req_op",    32'(rng_if.rng_req_op), 32'b100);
    wait_ready(10, cyc);
    chk("test_ready",   32'(ready), 32'd1);
    chk("test_latency", 32'(1 + cyc), 32'd3);
    chk("test_result",  result, 32'd1);
    pipeline_progress = 1'b1;
    @(negedge g_clk); valid = 1'b0; uop_test = 1'b0; pipeline_progress = 1'b0;
    p0 = pf_ops;
    wait_full(12, cyc);
    chk("fill_count",  32'(count), 32'd4);
    chk("fill_cycles", 32'(cyc <= 9), 32'd1);
    chk("fill_pf_ops", 32'(pf_ops - p0), 32'd4);
    chk("full_no_req", 32'(rng_if.rng_req_valid), 32'd0);

    // four back-to-back hits, prefetch held off by req_ready low
    rng_if.rng_req_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge g_clk); valid = 1'b1; uop_samp = 1'b1; pipeline_progress = 1'b1;
      #1;
      chk("hit_count",  32'(count), 32'(4 - k));
      chk("hit_ready",  32'(ready), 32'd1);
      chk("hit_result", result, 32'h5A00_0001 + 32'(k));
    end
    @(negedge g_clk); valid = 1'b0; uop_samp = 1'b0; pipeline_progress = 1'b0;
    #1;
    chk("drain_count", 32'(count), 32'd0);
    chk("pf_resume_valid", 32'(rng_if.rng_req_valid), 32'd1);
    chk("pf_resume_op",    32'(rng_if.rng_req_op), 32'b010);
    rng_if.rng_req_ready = 1'b1;
    p0 = pf_ops;
    wait_full(20, cyc);
    chk("refill_count",  32'(count), 32'd4);
    chk("refill_pf_ops", 32'(pf_ops - p0), 32'd4);

    // pop one (sample 5), then seed with count 3
    @(negedge g_clk); valid = 1'b1; uop_samp = 1'b1; pipeline_progress = 1'b1;
    #1;
    chk("pop5_result", result, 32'h5A00_0005);
    @(negedge g_clk); uop_samp = 1'b0; pipeline_progress = 1'b0;
    uop_seed = 1'b1; rs1 = 32'hDEAD_BEEF;
    #1;
    chk("seed_no_ready", 32'(ready), 32'd0);
    @(negedge g_clk); #1;
    chk("seed_req_valid", 32'(rng_if.rng_req_valid), 32'd1);
    chk("seed_req_op",    32'(rng_if.rng_req_op), 32'b001);
    chk("seed_req_data",  rng_if.rng_req_data, 32'hDEAD_BEEF);
    chk("seed_pre_count", 32'(count), 32'd3);
    @(negedge g_clk); #1;
    chk("seed_clr_count", 32'(count), 32'd0);
    wait_ready(10, cyc);
    chk("seed_ready",  32'(ready), 32'd1);
    chk("seed_result", result, 32'd0);

    // direct samp on empty buffer beats prefetch
    pipeline_progress = 1'b1;
    @(negedge g_clk); pipeline_progress = 1'b0; uop_seed = 1'b0; uop_samp = 1'b1; rs1 = 32'd0;
    #1;
    chk("miss_no_hit", 32'(ready), 32'd0);
    @(negedge g_clk); #1;
    chk("miss_req_op",    32'(rng_if.rng_req_op), 32'b010);
    chk("miss_req_valid", 32'(rng_if.rng_req_valid), 32'd1);
    wait_ready(10, cyc);
    chk("miss_ready",  32'(ready), 32'd1);
    chk("miss_result", result, 32'h5A00_000A);
    chk("miss_count",  32'(count), 32'd0);
    pipeline_progress = 1'b1;
    @(negedge g_clk); valid = 1'b0; uop_samp = 1'b0; pipeline_progress = 1'b0;
    #1;
    chk("miss_ready_1cyc", 32'(ready), 32'd0);

    // flush during CPU_RSP with delayed response
    wait_full(20, cyc);
    chk("refill2_count", 32'(count), 32'd4);
    rsp_dly_cfg = 5;
    f0 = rsp_fires;
    @(negedge g_clk); valid = 1'b1; uop_test = 1'b1;
    @(negedge g_clk);
    @(negedge g_clk); flush = 1'b1; valid = 1'b0; uop_test = 1'b0;
    #1;
    chk("flush_rsp_ready", 32'(rng_if.rng_rsp_ready), 32'd1);
    seen = ready;
    for (int k = 0; k < 12; k++) begin
      @(negedge g_clk); flush = 1'b0;
      #1;
      if (ready) seen = 1'b1;
    end
    rsp_dly_cfg = 0;
    chk("flush_no_ready",  32'(seen), 32'd0);
    chk("flush_rsp_drain", 32'(rsp_fires - f0), 32'd1);
    chk("flush_idle_rsp",  32'(rng_if.rng_rsp_ready), 32'd0);
    chk("flush_idle_req",  32'(rng_if.rng_req_valid), 32'd0);
    chk("flush_count",     32'(count), 32'd4);

    // unhealthy prefetch response
    rsp_status_cfg = 3'd4;
    @(negedge g_clk); valid = 1'b1; uop_samp = 1'b1; pipeline_progress = 1'b1;
    #1;
    chk("pop11_result", result, 32'h5A00_000B);
    @(negedge g_clk); valid = 1'b0; uop_samp = 1'b0; pipeline_progress = 1'b0;
    p0 = pf_ops;
    repeat (10) @(negedge g_clk);
    #1;
    chk("bad_no_push",  32'(count), 32'd3);
    chk("bad_one_pf",   32'(pf_ops - p0), 32'd1);
    chk("bad_pf_stops", 32'(rng_if.rng_req_valid), 32'd0);
    rsp_status_cfg = 3'd1;
    @(negedge g_clk); valid = 1'b1; uop_test = 1'b1;
    wait_ready(10, cyc);
    chk("heal_ready",  32'(ready), 32'd1);
    chk("heal_result", result, 32'd1);
    pipeline_progress = 1'b1;
    @(negedge g_clk); valid = 1'b0; uop_test = 1'b0; pipeline_progress = 1'b0;
    wait_full(10, cyc);
    chk("heal_refill", 32'(count), 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
